// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight destination registers per stage,
// stalls ID on load-use hazards and produces registered EX operand forward selects.
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16,
  localparam int FW_W    = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic              id_ra_en,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_rb_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [FW_W-1:0]   fwd_a,
  output logic [FW_W-1:0]   fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [STAGES:1]   slot_valid;
  logic [STAGES:1]   slot_load;
  logic [REG_AW-1:0] slot_rd [1:STAGES];

  logic            hit_a, hit_b, ld_a, ld_b, haz_a, haz_b, advance;
  logic [FW_W-1:0] sel_a, sel_b, code_a, code_b;

  // Scan oldest to youngest so the youngest (lowest slot) match overwrites.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (id_ra_en && id_ra != ZR && slot_valid[k] && slot_rd[k] == id_ra) begin
        hit_a = 1'b1;
        ld_a  = slot_load[k];
        sel_a = FW_W'(k);
      end
      if (id_rb_en && id_rb != ZR && slot_valid[k] && slot_rd[k] == id_rb) begin
        hit_b = 1'b1;
        ld_b  = slot_load[k];
        sel_b = FW_W'(k);
      end
    end
  end

  // Code k selects the slot-k pipeline register once the consumer sits in EX;
  // the oldest slot is covered by the regfile write-through, so it reads as 0.
  always_comb begin
    haz_a   = hit_a && ld_a && (sel_a < FW_W'(LOAD_LAT));
    haz_b   = hit_b && ld_b && (sel_b < FW_W'(LOAD_LAT));
    stall   = id_valid && !flush && (haz_a || haz_b);
    advance = id_valid && !flush && !stall;
    code_a  = (hit_a && sel_a != FW_W'(STAGES)) ? sel_a : '0;
    code_b  = (hit_b && sel_b != FW_W'(STAGES)) ? sel_b : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 1; k <= STAGES; k++) slot_rd[k] <= '0;
      fwd_a      <= '0;
      fwd_b      <= '0;
      stall_cnt  <= '0;
    end else begin
      for (int k = 2; k <= STAGES; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
      slot_valid[1] <= advance && id_wr && id_rd != ZR;
      slot_load[1]  <= advance && id_load;
      slot_rd[1]    <= id_rd;
      fwd_a         <= advance ? code_a : '0;
      fwd_b         <= advance ? code_b : '0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed instruction pairs with
// expectations queued at drive time and popped when the DUT output is sampled.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_ra_en = 1'b0, id_rb_en = 1'b0;
  logic       id_wr = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic [4:0] id_ra = '0, id_rb = '0, id_rd = '0;

  logic        stall, stall5;
  logic [1:0]  fwd_a, fwd_b;
  logic [2:0]  fwd_a5, fwd_b5;
  logic [15:0] stall_cnt, stall_cnt5;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ra(id_ra), .id_ra_en(id_ra_en), .id_rb(id_rb), .id_rb_en(id_rb_en),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  pipe_hazard_unit #(.STAGES(5), .LOAD_LAT(4)) dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ra(id_ra), .id_ra_en(id_ra_en), .id_rb(id_rb), .id_rb_en(id_rb_en),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .flush(flush),
    .stall(stall5), .fwd_a(fwd_a5), .fwd_b(fwd_b5), .stall_cnt(stall_cnt5)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: expectation queued when stimulus is set up, consumed on sample.
  task automatic push(input logic [31:0] exp);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0d with no expectation queued", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Driver tasks: inputs change 1 ns after posedge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic ra_en,
                       input logic [4:0] rb, input logic rb_en, input logic [4:0] rd,
                       input logic wr, input logic ld);
    id_valid = v;  id_ra = ra; id_ra_en = ra_en; id_rb = rb; id_rb_en = rb_en;
    id_rd = rd;    id_wr = wr; id_load = ld;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    bubble();
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bubble();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    int stalls;
    logic [15:0] cnt_base;

    do_reset();
    sample();
    push(0); pop_check("reset_stall", stall);
    push(0); pop_check("reset_fwd_a", fwd_a);
    push(0); pop_check("reset_fwd_b", fwd_b);
    push(0); pop_check("reset_cnt", stall_cnt);
    tick();

    // 1: ADD X1 ; ADD X2,X1,X3 -> no stall, fwd_a=1
    drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);
    tick();
    drive(1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0);
    push(0); push(1); push(0);
    sample(); pop_check("alu_alu_stall", stall);
    tick(); bubble();
    sample(); pop_check("alu_alu_fwd_a", fwd_a); pop_check("alu_alu_fwd_b", fwd_b);
    drain();

    // 2: LDUR X1 ; ADD X2,X1,X1 -> one stall, then fwd_a=fwd_b=2
    drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 1);
    tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
    push(1); push(0);
    sample(); pop_check("ld_use_stall1", stall); pop_check("ld_use_cnt0", stall_cnt);
    tick();
    push(0); push(1); push(0);
    sample(); pop_check("ld_use_stall2", stall); pop_check("ld_use_cnt1", stall_cnt);
    pop_check("ld_use_fwd_held", fwd_a);
    tick(); bubble();
    push(2); push(2);
    sample(); pop_check("ld_use_fwd_a", fwd_a); pop_check("ld_use_fwd_b", fwd_b);
    drain();

    // 3: ADD X31 ; SUB X4,X31,X5 -> zero register never forwards
    drive(1, 5'd2, 1, 5'd3, 1, 5'd31, 1, 0);
    tick();
    drive(1, 5'd31, 1, 5'd5, 1, 5'd4, 1, 0);
    push(0); push(0);
    sample(); pop_check("zr_stall", stall);
    tick(); bubble();
    sample(); pop_check("zr_fwd_a", fwd_a);
    drain();

    // 4: LDUR X1 ; ADD X1 ; reader of X1 -> youngest ALU writer wins
    drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 1);
    tick();
    drive(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);
    tick();
    drive(1, 5'd1, 1, 5'd6, 1, 5'd7, 1, 0);
    push(0); push(1);
    sample(); pop_check("young_stall", stall);
    tick(); bubble();
    sample(); pop_check("young_fwd_a", fwd_a);
    drain();

    // 5: LDUR X1 ; dependent flushed in hazard cycle -> no stall, bubble in slot1
    cnt_base = stall_cnt;
    drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 1);
    tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
    flush = 1'b1;
    push(0);
    sample(); pop_check("flush_stall", stall);
    tick();
    flush = 1'b0;
    drive(1, 5'd2, 1, 5'd0, 0, 5'd8, 1, 0);
    push({16'd0, cnt_base}); push(0); push(0);
    sample(); pop_check("flush_cnt", stall_cnt); pop_check("flush_fwd_a", fwd_a);
    pop_check("flush_reader_stall", stall);
    tick(); bubble();
    push(0);
    sample(); pop_check("flush_bubble_fwd", fwd_a);
    drain();

    // 6: reset held during a load-use stall
    drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 1);
    tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
    push(1);
    sample(); pop_check("rst_pre_stall", stall);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    push(0); push(0); push(0); push(0);
    sample(); pop_check("rst_stall", stall); pop_check("rst_fwd_a", fwd_a);
    pop_check("rst_fwd_b", fwd_b); pop_check("rst_cnt", stall_cnt);
    drain();

    // 7: STAGES=5, LOAD_LAT=4 -> three stall cycles, then forward from slot 4
    do_reset();
    drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 1);
    tick();
    drive(1, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
    stalls = 0;
    sample();
    for (int i = 0; i < 20 && stall5; i++) begin
      stalls++;
      tick();
      sample();
    end
    push(3); push(0); push(3);
    pop_check("deep_stall_cycles", stalls);
    pop_check("deep_stall_drop", stall5);
    pop_check("deep_cnt", stall_cnt5);
    tick(); bubble();
    push(4); push(4);
    sample(); pop_check("deep_fwd_a", fwd_a5); pop_check("deep_fwd_b", fwd_b5);
    drain();

    if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
